cache_refill_ctrl: RTL

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: optional dirty-victim writeback, then WORDS-beat line read, then a one-cycle response.
// Latency: first beat is presented the cycle after the miss is accepted; each beat takes at least one cycle; response follows the last read ack.
// Backpressure: the memory stalls a beat by withholding i_mem_ack; the request, address and write data hold until the ack.
module cache_refill_ctrl #(
    parameter int LINE_SIZE_BYTES = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int OFFSET_BITS     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss,
    input  logic [ADDRESS_WIDTH-1:0]     i_miss_addr,
    input  logic                         i_evict,
    input  logic [ADDRESS_WIDTH-1:0]     i_evict_addr,
    input  logic [LINE_SIZE_BYTES*8-1:0] i_evict_line,
    output logic [LINE_SIZE_BYTES*8-1:0] o_memory_line,
    output logic                         o_memory_response,
    output logic                         o_mem_req,
    output logic                         o_mem_we,
    output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    input  logic                         i_mem_ack,
    input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
    output logic                         o_busy
);

    localparam int LINE_BITS  = LINE_SIZE_BYTES * 8;
    localparam int WORDS      = LINE_BITS / DATA_WIDTH;
    localparam int CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BEAT_BYTES = DATA_WIDTH / 8;

    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
        (ADDRESS_WIDTH'(1) << OFFSET_BITS) - ADDRESS_WIDTH'(1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           beat;
    logic [ADDRESS_WIDTH-1:0]   miss_base;
    logic [ADDRESS_WIDTH-1:0]   evict_base;
    logic [LINE_BITS-1:0]       evict_line;

    logic [CNT_W-1:0]           next_beat;
    logic [ADDRESS_WIDTH-1:0]   miss_base_in;
    logic [ADDRESS_WIDTH-1:0]   evict_base_in;

    // Line bases are aligned, so beat offsets never carry out of the offset field.
    assign next_beat     = beat + CNT_W'(1);
    assign miss_base_in  = i_miss_addr & ~OFFSET_MASK;
    assign evict_base_in = i_evict_addr & ~OFFSET_MASK;

    function automatic logic [ADDRESS_WIDTH-1:0] beat_addr(
        input logic [ADDRESS_WIDTH-1:0] base,
        input logic [CNT_W-1:0]         b
    );
        return base + ADDRESS_WIDTH'(b) * ADDRESS_WIDTH'(BEAT_BYTES);
    endfunction

    // Refill FSM; all memory-side and cache-side outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            beat              <= '0;
            miss_base         <= '0;
            evict_base        <= '0;
            evict_line        <= '0;
            o_memory_line     <= '0;
            o_memory_response <= 1'b0;
            o_mem_req         <= 1'b0;
            o_mem_we          <= 1'b0;
            o_mem_addr        <= '0;
            o_mem_wdata       <= '0;
            o_busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_memory_response <= 1'b0;
                    if (i_miss) begin
                        miss_base  <= miss_base_in;
                        evict_base <= evict_base_in;
                        evict_line <= i_evict_line;
                        beat       <= '0;
                        o_busy     <= 1'b1;
                        o_mem_req  <= 1'b1;
                        if (i_evict) begin
                            state       <= WB;
                            o_mem_we    <= 1'b1;
                            o_mem_addr  <= evict_base_in;
                            o_mem_wdata <= i_evict_line[DATA_WIDTH-1:0];
                        end else begin
                            state      <= RD;
                            o_mem_we   <= 1'b0;
                            o_mem_addr <= miss_base_in;
                        end
                    end
                end
                WB: begin
                    if (o_mem_req && i_mem_ack) begin
                        if (beat == LAST_BEAT) begin
                            // Writeback finished: switch to reading the missing line.
                            beat       <= '0;
                            state      <= RD;
                            o_mem_we   <= 1'b0;
                            o_mem_addr <= miss_base;
                        end else begin
                            beat        <= next_beat;
                            o_mem_addr  <= beat_addr(evict_base, next_beat);
                            o_mem_wdata <= evict_line[int'(next_beat)*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                RD: begin
                    if (o_mem_req && i_mem_ack) begin
                        o_memory_line[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
                        if (beat == LAST_BEAT) begin
                            beat              <= '0;
                            state             <= RESP;
                            o_mem_req         <= 1'b0;
                            o_memory_response <= 1'b1;
                        end else begin
                            beat       <= next_beat;
                            o_mem_addr <= beat_addr(miss_base, next_beat);
                        end
                    end
                end
                RESP: begin
                    o_memory_response <= 1'b0;
                    o_busy            <= 1'b0;
                    state             <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
